// File: rtl/cen_gen_multi.sv
// cen_gen_multi
// Multi-channel clock-enable generator. Every channel divides clk_sys by a
// runtime-programmable terminal count. It produces a one-cycle main enable
// (cen) once per period and a one-cycle mid-period enable (cen_h).
// A new divisor written through div_wr is held as pending. It takes effect
// only when that channel wraps, so the enables never glitch.
//
// Ports:
//   clk_sys   in   system clock, all logic on its rising edge
//   reset     in   synchronous active-high reset
//   div_in    in   CHANNELS*CNT_W new terminal counts, channel i at [i*CNT_W +: CNT_W]
//   div_wr    in   per-channel write strobe for div_in
//   pause     in   freeze all counters and suppress all enables
//   resync    in   zero all counters and apply pending divisors immediately
//   cen       out  per-channel main enable, one cycle wide, period = div+1
//   cen_h     out  per-channel half-period enable, one cycle wide
//   upd_pend  out  per-channel flag: divisor captured but not yet applied
module cen_gen_multi #(
  parameter int                          CHANNELS    = 2,
  parameter int                          CNT_W       = 8,
  parameter logic [CHANNELS*CNT_W-1:0]   DEFAULT_DIV = {8'd16, 8'd47}
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [CHANNELS*CNT_W-1:0]     div_in,
  input  logic [CHANNELS-1:0]           div_wr,
  input  logic                          pause,
  input  logic                          resync,
  output logic [CHANNELS-1:0]           cen,
  output logic [CHANNELS-1:0]           cen_h,
  output logic [CHANNELS-1:0]           upd_pend
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             cen_q, cen_d;
    logic             cen_h_q, cen_h_d;
    logic [CNT_W-1:0] div_slice;
    logic             at_wrap;
    logic             at_half;

    assign div_slice = div_in[g*CNT_W +: CNT_W];
    assign at_wrap   = (cnt_q == div_act_q);
    // A zero divisor wraps every cycle, so it has no meaningful midpoint.
    assign at_half   = (cnt_q == (div_act_q >> 1)) && (div_act_q != '0);

    always_comb begin
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_d     = pend_q;
      cen_d      = 1'b0;
      cen_h_d    = 1'b0;

      if (resync) begin
        // Only a captured divisor is applied. The stale div_pend contents
        // must not clobber the active divisor when nothing was written.
        cnt_d = '0;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end else if (!pause) begin
        cen_h_d = at_half;
        if (at_wrap) begin
          // cnt is zero whenever div_act changes, so it never exceeds div_act.
          cnt_d = '0;
          cen_d = 1'b1;
          if (pend_q) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A write takes precedence over an apply on the same edge. The wrap or
      // resync then uses the older pending value, and the new one waits.
      if (div_wr[g]) begin
        div_pend_d = div_slice;
        pend_d     = 1'b1;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        cnt_q      <= '0;
        div_act_q  <= DEFAULT_DIV[g*CNT_W +: CNT_W];
        div_pend_q <= '0;
        pend_q     <= 1'b0;
        cen_q      <= 1'b0;
        cen_h_q    <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_q     <= pend_d;
        cen_q      <= cen_d;
        cen_h_q    <= cen_h_d;
      end
    end

    assign cen[g]      = cen_q;
    assign cen_h[g]    = cen_h_q;
    assign upd_pend[g] = pend_q;
  end

endmodule

// File: tb/tb_cen_gen_multi.sv
// tb_cen_gen_multi
// Directed bench for cen_gen_multi with the default parameters (2 channels,
// 8-bit counters, reset divisors 47 on channel 0 and 16 on channel 1).
// edge_n counts rising edges since reset release. Expected enables are
// hand-derived from that count.
module tb_cen_gen_multi;

  logic        clk_sys;
  logic        reset;
  logic [15:0] div_in;
  logic [1:0]  div_wr;
  logic        pause;
  logic        resync;
  logic [1:0]  cen;
  logic [1:0]  cen_h;
  logic [1:0]  upd_pend;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  typedef struct {
    int         ncyc;
    logic [1:0] wr;
    logic [15:0] din;
    logic       pause;
    logic       resync;
    logic [1:0] ec;
    logic [1:0] eh;
    logic [1:0] eu;
  } vec_t;

  vec_t tbl [22];

  cen_gen_multi dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .div_in   (div_in),
    .div_wr   (div_wr),
    .pause    (pause),
    .resync   (resync),
    .cen      (cen),
    .cen_h    (cen_h),
    .upd_pend (upd_pend)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "[TB] timeout");
  end

  task automatic stepEdge();
    @(posedge clk_sys);
    #1;
    edge_n++;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ec,
                             input logic [1:0] eh, input logic [1:0] eu);
    n_checks++;
    if ({cen, cen_h, upd_pend} !== {ec, eh, eu}) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: cen/cen_h/upd_pend = %b/%b/%b, expected %b/%b/%b",
               name, edge_n, cen, cen_h, upd_pend, ec, eh, eu);
    end
  endtask

  // Strobes are only asserted on the first edge of a record. Pause and
  // resync are held for all of its edges. The check follows the last edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    div_in = v.din;
    div_wr = v.wr;
    pause  = v.pause;
    resync = v.resync;
    for (int k = 0; k < v.ncyc; k++) begin
      stepEdge();
      div_wr = 2'b00;
    end
    pause  = 1'b0;
    resync = 1'b0;
    checkOutput($sformatf("table[%0d]", idx), v.ec, v.eh, v.eu);
  endtask

  initial begin
    logic c0, c1, h0, h1;
    logic [1:0] u;

    //           ncyc  wr     din              pause resync cen    cen_h  upd
    tbl[0]  = '{1,   2'b11, {8'd16, 8'd47}, 1'b0, 1'b1, 2'b00, 2'b00, 2'b11};
    tbl[1]  = '{1,   2'b00, 16'd0,          1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{9,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
    tbl[3]  = '{8,   2'b00, 16'd0,          1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
    tbl[4]  = '{7,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[5]  = '{6,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{100, 2'b00, 16'd0,          1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{4,   2'b00, 16'd0,          1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
    tbl[8]  = '{14,  2'b00, 16'd0,          1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
    tbl[9]  = '{1,   2'b11, {8'd9, 8'd9},   1'b0, 1'b0, 2'b00, 2'b00, 2'b11};
    tbl[10] = '{2,   2'b00, 16'd0,          1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{5,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b11, 2'b00};
    tbl[12] = '{5,   2'b00, 16'd0,          1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
    tbl[13] = '{7,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[14] = '{2,   2'b00, 16'd0,          1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[15] = '{1,   2'b10, {8'd3, 8'd0},   1'b1, 1'b0, 2'b00, 2'b00, 2'b10};
    tbl[16] = '{1,   2'b00, 16'd0,          1'b1, 1'b1, 2'b00, 2'b00, 2'b00};
    tbl[17] = '{2,   2'b00, 16'd0,          1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    tbl[18] = '{2,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
    tbl[19] = '{2,   2'b00, 16'd0,          1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
    tbl[20] = '{1,   2'b00, 16'd0,          1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
    tbl[21] = '{5,   2'b00, 16'd0,          1'b0, 1'b0, 2'b01, 2'b10, 2'b00};

    reset  = 1'b1;
    div_in = 16'd0;
    div_wr = 2'b00;
    pause  = 1'b0;
    resync = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("reset state", 2'b00, 2'b00, 2'b00);
    reset  = 1'b0;
    edge_n = 0;

    // Default divisors: channel 0 period 48, half at +24; channel 1 period 17, half at +9.
    for (int e = 1; e <= 500; e++) begin
      stepEdge();
      checkOutput("default divisors", {(e % 17) == 0, (e % 48) == 0},
                  {(e % 17) == 9, (e % 48) == 24}, 2'b00);
    end

    // Channel 0 is at cnt 20 here. Write 11, which applies at the wrap on edge 528.
    for (int e = 501; e <= 600; e++) begin
      if (e == 501) begin
        div_in = {8'd0, 8'd11};
        div_wr = 2'b01;
      end
      stepEdge();
      div_wr = 2'b00;
      c0 = (e <= 528) ? ((e % 48) == 0)  : (((e - 528) % 12) == 0);
      h0 = (e <= 528) ? ((e % 48) == 24) : (((e - 528) % 12) == 6);
      u  = (e < 528) ? 2'b01 : 2'b00;
      checkOutput("mid-period update", {(e % 17) == 0, c0},
                  {(e % 17) == 9, h0}, u);
    end

    // The write of 5 lands on the wrap edge 612, and 7 overwrites it. The wrap
    // on edge 612 keeps period 12, and 7 applies at the wrap on edge 624.
    for (int e = 601; e <= 660; e++) begin
      if (e == 612) begin
        div_in = {8'd0, 8'd5};
        div_wr = 2'b01;
      end else if (e == 615) begin
        div_in = {8'd0, 8'd7};
        div_wr = 2'b01;
      end
      stepEdge();
      div_wr = 2'b00;
      c0 = (e <= 624) ? (((e - 528) % 12) == 0) : (((e - 624) % 8) == 0);
      h0 = (e <= 624) ? (((e - 528) % 12) == 6) : (((e - 624) % 8) == 4);
      u  = (e >= 612 && e < 624) ? 2'b01 : 2'b00;
      checkOutput("write on wrap edge", {(e % 17) == 0, c0},
                  {(e % 17) == 9, h0}, u);
    end

    // Channel 1 gets divisor 0, applied at its wrap on edge 663. It then gets
    // divisor 1, written on edge 681 and applied at edge 682.
    for (int e = 661; e <= 700; e++) begin
      if (e == 661) begin
        div_in = 16'h0000;
        div_wr = 2'b10;
      end else if (e == 681) begin
        div_in = 16'h0100;
        div_wr = 2'b10;
      end
      stepEdge();
      div_wr = 2'b00;
      c0 = ((e - 624) % 8) == 0;
      h0 = ((e - 624) % 8) == 4;
      if (e < 663) begin
        c1 = (e % 17) == 0;
        h1 = (e % 17) == 9;
      end else if (e <= 682) begin
        c1 = 1'b1;
        h1 = 1'b0;
      end else begin
        c1 = (e % 2) == 0;
        h1 = (e % 2) == 1;
      end
      u = ((e >= 661 && e < 663) || e == 681) ? 2'b10 : 2'b00;
      checkOutput("divisor 0/1", {c1, c0}, {h1, h0}, u);
    end

    // Resync with a simultaneous write, pause at cnt 30, and resync to equal
    // divisors. Then resync during pause.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i], i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cen_gen_multi.md
Name: cen_gen_multi

Overview:
- Parametrised multi-channel clock-enable generator for arcade cores. Replaces the hand-written per-domain divide counters (CPU enable, pixel enable) in the emu top level.
- Each channel produces a one-cycle main enable pulse and a mid-period enable pulse, both derived from clk_sys.
- Divisors are runtime-programmable and updates are glitch-free (applied only at a period boundary).
- Global pause and phase-resync controls are provided for PAL/NTSC switching and for save/restore.

Parameters:
- CHANNELS, 2, number of independent enable channels.
- CNT_W, 8, width of each channel's divide counter and divisor.
- DEFAULT_DIV, {8'd16, 8'd47}, CHANNELS*CNT_W reset divisors (terminal counts); channel i uses slice [i*CNT_W +: CNT_W].

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- div_in  in  CHANNELS*CNT_W  new terminal count per channel; period = value+1 cycles.
- div_wr  in  CHANNELS  per-channel strobe; captures that channel's div_in slice.
- pause  in  1  freeze all counters and suppress all enables.
- resync  in  1  restart all channels phase-aligned at count 0.
- cen  out  CHANNELS  main enable, one clk_sys cycle wide.
- cen_h  out  CHANNELS  half-period enable, one cycle wide.
- upd_pend  out  CHANNELS  divisor update captured but not yet applied.

Behaviour:
- Per-channel state: cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend flag. All outputs are registered.
- Reset (highest priority): cnt=0, div_act=DEFAULT_DIV slice, div_pend=0, pend=0, cen=0, cen_h=0, upd_pend=0.
- Normal run (pause=0, resync=0), each edge:
  - If cnt==div_act: cnt<=0, cen<=1; if pend, div_act<=div_pend and pend<=0.
  - Else: cnt<=cnt+1, cen<=0.
- Period is exactly div_act+1 cycles. After reset release the first cen is high in the cycle following the (div_act+1)th rising edge.
- cen_h<=1 on an edge where cnt==(div_act>>1) and div_act!=0; otherwise cen_h<=0.
  - div_act=1: cen and cen_h alternate every cycle.
  - div_act=47: cen_h rises 24 cycles after cen.
- div_act=0: cen is high every cycle and cen_h stays 0.
- div_wr[i]=1: div_pend<=div_in slice, pend<=1.
  - A write on the same edge as a wrap does not affect that wrap; the new value is applied at the next wrap.
  - A second write before the wrap overwrites the first; the last write wins.
- upd_pend mirrors pend.
- Because updates apply only at the wrap, cnt is always 0 when div_act changes, so cnt can never exceed div_act.
- pause=1: cnt holds, cen<=0, cen_h<=0, div_act unchanged. div_wr is still captured into div_pend/pend.
- On pause release, counting resumes from the held cnt; no pulse is lost or duplicated relative to unpaused cycles.
- resync=1 (priority over pause):
  - All channels: cnt<=0, cen<=0, cen_h<=0.
  - Pending divisors are applied immediately (div_act<=div_pend, pend<=0). A div_wr on the same edge is captured into pend, not applied.
  - Resync held high keeps all channels at cnt=0.
  - After release, channels with equal div_act emit cen on the same cycle.
- Counter arithmetic wraps modulo 2^CNT_W, which is never reached since cnt<=div_act.
- Channels are fully independent apart from pause, resync and reset.

Test Plan:
- Reset release, default divisors {16,47}, run 500 cycles -> cen[0] every 48 cycles (first high after the 48th edge), cen[1] every 17 cycles, cen_h[0] exactly 24 cycles after each cen[0].
- div_in[7:0]=11 with div_wr[0] mid-period, cnt=20 -> upd_pend[0]=1 until the current 48-cycle period completes, then period 12, upd_pend[0]=0, no short or long pulse gap.
- div_wr[0] issued on the exact wrap edge with value 5, then a second write of 7 before the next wrap -> wrap N keeps the old period, subsequent period is 8 cycles (value 7).
- Divisor 0 and divisor 1 on channel 1 -> div 0: cen[1] constant 1, cen_h[1]=0; div 1: cen[1] and cen_h[1] alternate 1010/0101.
- pause high for 100 cycles at cnt=30 -> no cen/cen_h during pause; first cen 18 cycles after release (div 47).
- resync pulse with channels at different phases and both divisors set to 9 -> both cen high simultaneously 10 cycles after resync release; resync during pause still zeroes the counters.
